pipe_mem_sched: RTL and testbench
=================================

Name: pipe_mem_sched

Overview:
- Scheduler for a single unified memory port shared by the instruction-fetch stage and the data-memory stage of the 5-stage pipeline.
- Each pipeline step it serializes up to two accesses: data first, then fetch.
- It holds one global stall (same sense as an inverted nostall) until every access requested in that step has completed.
- It buffers read results for the stages and includes an ack-timeout watchdog.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TO_CYC, 255, max cycles waiting for mem_ack before the access is force-completed (1..65535).

Ports:
- clk        in   1   clock, all state on rising edge
- clrn       in   1   asynchronous active-low reset
- if_req     in   1   fetch wanted this step
- if_addr    in   AW  fetch address (pc)
- if_rdata   out  DW  fetched instruction, valid while if_done
- dm_re      in   1   load in MEM stage
- dm_we      in   1   store in MEM stage
- dm_addr    in   AW  data address
- dm_wdata   in   DW  store data
- dm_rdata   out  DW  load data, valid while dm_done
- stall      out  1   hold pc/pipeline registers; pipe advances on an edge where stall=0
- mem_req    out  1   memory request, held until ack
- mem_we     out  1   write strobe
- mem_addr   out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in   DW  read data, valid when mem_ack=1
- mem_ack    in   1   one-cycle completion pulse
- bus_err    out  1   sticky: a timeout occurred

Behaviour:
- Reset (clrn=0, async):
  - state=IDLE; if_done=dm_done=0; if_rdata=dm_rdata=0; bus_err=0; wait counter=0.
  - mem_req=0; stall is then purely combinational from the requests.
- Definitions: dm_act = dm_re|dm_we; dm_we has priority if both are set.
- stall = (if_req & ~if_done) | (dm_act & ~dm_done), combinational from registered done flags.
- Requesters must hold req/addr/wdata stable while stall=1.
- FSM states: IDLE, DATA, INST (2-bit encoding 0, 1, 2).
  - IDLE -> DATA if dm_act & ~dm_done.
  - IDLE -> INST if (dm_act & ~dm_done) is false and if_req & ~if_done.
  - Otherwise stay in IDLE.
  - DATA/INST -> IDLE on mem_ack or timeout.
- Memory-side outputs:
  - mem_req = (state!=IDLE).
  - mem_addr/mem_we/mem_wdata are driven from dm_* in DATA and from if_addr in INST (mem_we=0 in INST); they are 0 in IDLE.
- mem_ack may arrive in the first mem_req cycle. mem_ack while in IDLE is ignored.
- On ack in DATA: dm_done<=1; dm_rdata<=mem_rdata if dm_re and not dm_we, else it is unchanged.
- On ack in INST: if_done<=1; if_rdata<=mem_rdata.
- Step end: on an edge with stall=0, if_done and dm_done clear to 0. The same edge advances the pipeline, and new requests are seen the next cycle.
- Latency with a 1-cycle-ack memory:
  - fetch only: stall high 2 cycles.
  - data+fetch: stall high 4 cycles.
  - no requests: stall=0 and no memory traffic.
- Watchdog: the counter increments each cycle in DATA/INST without ack and resets to 0 on entry to IDLE. When it reaches TO_CYC-1 with no ack:
  - the access is treated as acked with rdata=0;
  - bus_err<=1, and it stays 1 until reset;
  - the write is considered dropped.
- Simultaneous ack and timeout: the ack wins, and bus_err is not set.
- Requests dropping mid-access (protocol violation): the transaction still completes; the result is latched but unused.
- Reset mid-access: mem_req drops immediately and the access is abandoned. The memory is required to share clrn.

Decomposition:
- Shared package: state localparams (S_IDLE, S_DATA, S_INST), the watchdog counter width (clog2 of TO_CYC), and the AW/DW defaults.
- One natural sub-module: mem_wdog (counter with clear/enable, terminal-count output).

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0040, mem_ack 1 cycle after mem_req with rdata=0x2008_0005.
  Required: mem_addr=0x40, mem_we=0; stall high exactly 2 cycles; if_rdata=0x2008_0005; pipe advances.
- Load+fetch: dm_re=1, dm_addr=0x100 and if_addr=0x44 in the same step.
  Required: data issued first (mem_addr=0x100), then 0x44; stall high 4 cycles; dm_rdata and if_rdata both held until the advance edge.
- Store with wait states: dm_we=1, dm_addr=0x200, wdata=0xDEAD_BEEF, ack after 3 cycles.
  Required: mem_we=1; addr/wdata stable all 3 cycles; dm_rdata unchanged.
- Timeout with TO_CYC=4: no ack ever.
  Required: forced completion after 4 mem_req cycles; dm_rdata=0; bus_err=1 and stays 1 on later good accesses.
- Reset mid-access: clrn low during DATA.
  Required: mem_req=0 and state IDLE immediately; after release, the pending requests restart from DATA.
- Idle and stray ack: no requests and a stray mem_ack pulse.
  Required: stall=0, mem_req=0, no flag changes.

Source files
------------

// File: rtl/pipe_mem_sched_pkg.sv
// Shared definitions for the unified memory-port scheduler: FSM state
// encoding, default widths and the watchdog counter sizing helper.
package pipe_mem_sched_pkg;

  localparam int AW_DEF     = 32;
  localparam int DW_DEF     = 32;
  localparam int TO_CYC_DEF = 255;

  // Port owner: nobody, the data stage, or the fetch stage.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_INST = 2'd2
  } state_t;

  // Width able to hold 0..to_cyc-1, never narrower than one bit.
  function automatic int wdog_w(input int to_cyc);
    return (to_cyc < 2) ? 1 : $clog2(to_cyc);
  endfunction

endpackage

// File: rtl/pipe_mem_sched_wdog.sv
// Ack-timeout watchdog: counts busy cycles without an ack and flags the
// cycle in which the access has waited TO_CYC cycles in total.
module pipe_mem_sched_wdog
  import pipe_mem_sched_pkg::*;
#(
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = wdog_w(TO_CYC);
  localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt;

  // Terminal count only matters while an access is actually waiting.
  assign tc = en & (cnt == LAST);

  // Wait counter: cleared while idle or on completion, else counts up.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pipe_mem_sched.sv
// Scheduler for one unified memory port shared by instruction fetch and
// the data-memory stage. Per pipeline step it runs the data access first,
// then the fetch, and holds stall until every requested access is done.
//
// Handshake: mem_req is high for the whole access (state != IDLE) and the
// address/we/wdata are stable while it is high. The memory answers with a
// single-cycle mem_ack (allowed in the first mem_req cycle); read data is
// taken from mem_rdata on that same cycle. Requesters keep their request,
// address and write data stable while stall=1; the pipe advances on an
// edge where stall=0.
module pipe_mem_sched
  import pipe_mem_sched_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_re,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err,
  output logic [1:0]    dbg_state
);

  state_t state;
  logic   if_done;
  logic   dm_done;
  logic   dm_act;
  logic   dm_pend;
  logic   if_pend;
  logic   busy;
  logic   tc;

  assign dm_act    = dm_re | dm_we;
  assign dm_pend   = dm_act & ~dm_done;
  assign if_pend   = if_req & ~if_done;
  assign stall     = dm_pend | if_pend;
  assign busy      = (state != S_IDLE);
  assign mem_req   = busy;
  assign dbg_state = state;

  // Timeout watchdog; an ack in the terminal cycle still wins.
  pipe_mem_sched_wdog #(
    .TO_CYC(TO_CYC)
  ) u_wdog (
    .clk (clk),
    .clrn(clrn),
    .clr (~busy | mem_ack),
    .en  (busy & ~mem_ack),
    .tc  (tc)
  );

  // Memory-side drive: owner's address/data, all zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_DATA: begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      S_INST: begin
        mem_addr = if_addr;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Arbitration FSM with completion flags, read buffers and sticky error.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= S_IDLE;
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dm_pend) begin
            state <= S_DATA;
          end else if (if_pend) begin
            state <= S_INST;
          end
        end
        S_DATA: begin
          if (mem_ack | tc) begin
            state   <= S_IDLE;
            dm_done <= 1'b1;
            // A timed-out load reads as zero; a timed-out store is dropped.
            if (dm_re & ~dm_we) begin
              dm_rdata <= mem_ack ? mem_rdata : '0;
            end
            if (!mem_ack) begin
              bus_err <= 1'b1;
            end
          end
        end
        S_INST: begin
          if (mem_ack | tc) begin
            state    <= S_IDLE;
            if_done  <= 1'b1;
            if_rdata <= mem_ack ? mem_rdata : '0;
            if (!mem_ack) begin
              bus_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // Step end: the pipe advances on this edge, so the next step starts
      // with fresh completion flags.
      if (!stall) begin
        if_done <= 1'b0;
        dm_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_sched.sv
// Directed bench for pipe_mem_sched with a small scripted memory responder.
module tb_pipe_mem_sched;

  logic        clk;
  logic        clrn;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_re;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Memory responder controls: ack_delay = wait cycles before the ack
  // (0 = ack in first mem_req cycle, -1 = never ack).
  int   ack_delay = 0;
  int   req_cyc   = 0;
  logic resp_ack  = 1'b0;
  logic stray_ack = 1'b0;

  pipe_mem_sched #(
    .AW(32), .DW(32), .TO_CYC(4)
  ) dut (
    .clk(clk), .clrn(clrn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  // Memory content model
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2008_0005;
      32'h0000_0100: return 32'h1234_5678;
      32'h0000_0044: return 32'hAC22_0000;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign mem_rdata = mem_model(mem_addr);
  assign mem_ack   = resp_ack | stray_ack;

  // Responder: counts mem_req cycles of the current access and acks.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      req_cyc  = mem_req ? req_cyc + 1 : 0;
      resp_ack = mem_req && (ack_delay >= 0) && (req_cyc == ack_delay + 1);
    end
  end

  // Runs one pipeline step: samples on negedges until stall drops.
  task automatic run_step(output int st, output int nreq, output int nacc,
                          output logic [31:0] a0, output logic [31:0] a1,
                          output logic we0, output int unstable);
    logic        prev;
    logic [31:0] w0;
    st = 0; nreq = 0; nacc = 0; a0 = '0; a1 = '0; we0 = 1'b0;
    unstable = 0; prev = 1'b0; w0 = '0;
    @(negedge clk);
    while (stall && st < 50) begin
      st++;
      if (mem_req) begin
        nreq++;
        if (!prev) begin
          if (nacc == 0) begin
            a0 = mem_addr; we0 = mem_we; w0 = mem_wdata;
          end else begin
            a1 = mem_addr;
          end
          nacc++;
        end else if (nacc == 1 &&
                     (mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0)) begin
          unstable++;
        end
      end
      prev = mem_req;
      @(negedge clk);
    end
    if (st >= 50) begin
      errors++; checks++;
      $display("FAIL step_bound: stall still high after %0d cycles", st);
    end
  endtask

  task automatic end_step();
    @(posedge clk);
    #1;
    if_req = 1'b0; dm_re = 1'b0; dm_we = 1'b0;
  endtask

  // Driver tasks / scenarios
  task automatic test_reset();
    clrn = 1'b0; if_req = 1'b0; if_addr = '0; dm_re = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b exp 0", bus_err); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata: got %h exp 0", if_rdata); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_dm_rdata: got %h exp 0", dm_rdata); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    @(posedge clk); #1;
    clrn = 1'b1;
  endtask

  task automatic test_fetch_only();
    int st, nreq, nacc, unst; logic [31:0] a0, a1; logic we0;
    @(posedge clk); #1;
    ack_delay = 0; if_req = 1'b1; if_addr = 32'h40;
    run_step(st, nreq, nacc, a0, a1, we0, unst);
    checks++; if (st !== 2) begin errors++; $display("FAIL fetch_stall_cycles: got %0d exp 2", st); end
    checks++; if (a0 !== 32'h40) begin errors++; $display("FAIL fetch_addr: got %h exp 40", a0); end
    checks++; if (we0 !== 1'b0) begin errors++; $display("FAIL fetch_we: got %b exp 0", we0); end
    checks++; if (if_rdata !== 32'h2008_0005) begin errors++; $display("FAIL fetch_rdata: got %h exp 20080005", if_rdata); end
    end_step();
  endtask

  task automatic test_load_fetch();
    int st, nreq, nacc, unst; logic [31:0] a0, a1; logic we0;
    @(posedge clk); #1;
    ack_delay = 0; dm_re = 1'b1; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h44;
    run_step(st, nreq, nacc, a0, a1, we0, unst);
    checks++; if (st !== 4) begin errors++; $display("FAIL lf_stall_cycles: got %0d exp 4", st); end
    checks++; if (nacc !== 2) begin errors++; $display("FAIL lf_accesses: got %0d exp 2", nacc); end
    checks++; if (a0 !== 32'h100) begin errors++; $display("FAIL lf_first_addr: got %h exp 100", a0); end
    checks++; if (a1 !== 32'h44) begin errors++; $display("FAIL lf_second_addr: got %h exp 44", a1); end
    checks++; if (dm_rdata !== 32'h1234_5678) begin errors++; $display("FAIL lf_dm_rdata: got %h exp 12345678", dm_rdata); end
    checks++; if (if_rdata !== 32'hAC22_0000) begin errors++; $display("FAIL lf_if_rdata: got %h exp ac220000", if_rdata); end
    end_step();
  endtask

  task automatic test_store_wait();
    int st, nreq, nacc, unst; logic [31:0] a0, a1; logic we0;
    @(posedge clk); #1;
    ack_delay = 2; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    run_step(st, nreq, nacc, a0, a1, we0, unst);
    checks++; if (nreq !== 3) begin errors++; $display("FAIL st_req_cycles: got %0d exp 3", nreq); end
    checks++; if (st !== 4) begin errors++; $display("FAIL st_stall_cycles: got %0d exp 4", st); end
    checks++; if (we0 !== 1'b1) begin errors++; $display("FAIL st_we: got %b exp 1", we0); end
    checks++; if (a0 !== 32'h200) begin errors++; $display("FAIL st_addr: got %h exp 200", a0); end
    checks++; if (unst !== 0) begin errors++; $display("FAIL st_stable: got %0d unstable cycles exp 0", unst); end
    checks++; if (dm_rdata !== 32'h1234_5678) begin errors++; $display("FAIL st_dm_rdata: got %h exp 12345678", dm_rdata); end
    end_step();
    ack_delay = 0;
  endtask

  task automatic test_ack_at_limit();
    int st, nreq, nacc, unst; logic [31:0] a0, a1; logic we0;
    @(posedge clk); #1;
    ack_delay = 3; dm_re = 1'b1; dm_addr = 32'h300;
    run_step(st, nreq, nacc, a0, a1, we0, unst);
    checks++; if (nreq !== 4) begin errors++; $display("FAIL lim_req_cycles: got %0d exp 4", nreq); end
    checks++; if (dm_rdata !== 32'hA5A5_0300) begin errors++; $display("FAIL lim_dm_rdata: got %h exp a5a50300", dm_rdata); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL lim_bus_err: got %b exp 0", bus_err); end
    end_step();
    ack_delay = 0;
  endtask

  task automatic test_timeout();
    int st, nreq, nacc, unst; logic [31:0] a0, a1; logic we0;
    @(posedge clk); #1;
    ack_delay = -1; dm_re = 1'b1; dm_addr = 32'h400;
    run_step(st, nreq, nacc, a0, a1, we0, unst);
    checks++; if (nreq !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d exp 4", nreq); end
    checks++; if (st !== 5) begin errors++; $display("FAIL to_stall_cycles: got %0d exp 5", st); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL to_dm_rdata: got %h exp 0", dm_rdata); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err: got %b exp 1", bus_err); end
    end_step();
    @(posedge clk); #1;
    ack_delay = 0; if_req = 1'b1; if_addr = 32'h48;
    run_step(st, nreq, nacc, a0, a1, we0, unst);
    checks++; if (if_rdata !== 32'hA5A5_0048) begin errors++; $display("FAIL to_after_rdata: got %h exp a5a50048", if_rdata); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b exp 1", bus_err); end
    end_step();
  endtask

  task automatic test_reset_mid();
    int st, nreq, nacc, unst; logic [31:0] a0, a1; logic we0;
    @(posedge clk); #1;
    ack_delay = -1; dm_re = 1'b1; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h44;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_in_data: got %b exp 1", mem_req); end
    #2;
    clrn = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_req_drop: got %b exp 0", mem_req); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rm_state: got %0d exp 0", dbg_state); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rm_bus_err: got %b exp 0", bus_err); end
    @(posedge clk); #1;
    ack_delay = 0;
    clrn = 1'b1;
    run_step(st, nreq, nacc, a0, a1, we0, unst);
    checks++; if (st !== 4) begin errors++; $display("FAIL rm_stall_cycles: got %0d exp 4", st); end
    checks++; if (a0 !== 32'h100) begin errors++; $display("FAIL rm_first_addr: got %h exp 100", a0); end
    checks++; if (a1 !== 32'h44) begin errors++; $display("FAIL rm_second_addr: got %h exp 44", a1); end
    checks++; if (dm_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rm_dm_rdata: got %h exp 12345678", dm_rdata); end
    end_step();
  endtask

  task automatic test_idle_stray();
    int st, nreq, nacc, unst; logic [31:0] a0, a1; logic we0;
    int bad;
    ack_delay = -1; bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      stray_ack = (i == 1);
      @(negedge clk);
      if (stall !== 1'b0 || mem_req !== 1'b0 || dbg_state !== 2'd0) bad++;
    end
    stray_ack = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_quiet: got %0d busy cycles exp 0", bad); end
    checks++; if (dm_rdata !== 32'h1234_5678) begin errors++; $display("FAIL idle_dm_rdata: got %h exp 12345678", dm_rdata); end
    checks++; if (if_rdata !== 32'hAC22_0000) begin errors++; $display("FAIL idle_if_rdata: got %h exp ac220000", if_rdata); end
    @(posedge clk); #1;
    ack_delay = 0; if_req = 1'b1; if_addr = 32'h40;
    run_step(st, nreq, nacc, a0, a1, we0, unst);
    checks++; if (st !== 2) begin errors++; $display("FAIL idle_next_fetch: got %0d stall cycles exp 2", st); end
    end_step();
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_fetch_only();
    test_load_fetch();
    test_store_wait();
    test_ack_at_limit();
    test_timeout();
    test_reset_mid();
    test_idle_stray();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
